// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU op per handshake, holds operands and the
// one-hot result-mux select for a programmable settle time, then captures the
// mux result, multiplier upper half and error flags into the accumulator.
module alu_op_sequencer #(
  parameter int SETTLE_ALU = 1,
  parameter int SETTLE_MUL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic        use_acc,
  output logic [31:0] sel,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        mode,
  input  logic [15:0] mux_result,
  input  logic        add_overflow,
  input  logic [31:0] product,
  output logic        out_valid,
  output logic [15:0] acc,
  output logic [15:0] result_hi,
  output logic [1:0]  err
);

  localparam int SMAX = (SETTLE_MUL > SETTLE_ALU) ? SETTLE_MUL : SETTLE_ALU;
  localparam int CW   = (SMAX > 1) ? $clog2(SMAX) : 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_PSA = 4'd10;
  localparam logic [3:0] OP_CLR = 4'd11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  // operation as latched at accept; drives the datapath while settling
  typedef struct packed {
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          in_is_mux;
  logic          settle_end;

  // only the upper half of the product is consumed here; the low half reaches
  // the accumulator through the result mux
  logic unused_prod;
  assign unused_prod = ^product[15:0];

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign in_is_mux  = (opcode >= OP_ADD) && (opcode <= OP_PSA);
  assign settle_end = (state == SETTLE) && (cnt == '0);

  // only mux ops ever reach SETTLE, so the latched opcode is a legal select
  assign sel  = (state == SETTLE) ? (32'd1 << req_q.opc) : '0;
  assign op_a = req_q.a;
  assign op_b = req_q.b;
  assign mode = req_q.mode;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: mux ops settle, everything else captures at accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_is_mux ? SETTLE : DONE;
      SETTLE:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request latch and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      req_q.opc  <= opcode;
      req_q.a    <= use_acc ? acc : data_a;
      req_q.b    <= data_b;
      req_q.mode <= (opcode == OP_SUB);
      if (opcode == OP_MUL)  cnt <= CW'(SETTLE_MUL - 1);
      else if (in_is_mux)    cnt <= CW'(SETTLE_ALU - 1);
    end else if (state == SETTLE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // result capture: at settle end for mux ops, at accept for the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      result_hi <= '0;
      err       <= ERR_OK;
    end else if (settle_end) begin
      acc <= mux_result;
      if (req_q.opc == OP_MUL) begin
        result_hi <= product[31:16];
        err       <= (product[31:16] != '0) ? ERR_OVF : ERR_OK;
      end else begin
        result_hi <= '0;
        err       <= ((req_q.opc == OP_ADD || req_q.opc == OP_SUB) && add_overflow)
                     ? ERR_OVF : ERR_OK;
      end
    end else if (accept && !in_is_mux) begin
      result_hi <= '0;
      if (opcode == OP_CLR) acc <= '0;
      err <= (opcode == OP_NOP || opcode == OP_CLR) ? ERR_OK : ERR_ILL;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural datapath answers the
// select/operands, and a table of ops with hand-computed results is replayed.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] data_a, data_b;
  logic        use_acc;
  logic [31:0] sel;
  logic [15:0] op_a, op_b;
  logic        mode;
  logic [15:0] mux_result;
  logic        add_overflow;
  logic [31:0] product;
  logic        out_valid;
  logic [15:0] acc, result_hi;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_ALU(1), .SETTLE_MUL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .data_a(data_a), .data_b(data_b), .use_acc(use_acc),
    .sel(sel), .op_a(op_a), .op_b(op_b), .mode(mode),
    .mux_result(mux_result), .add_overflow(add_overflow), .product(product),
    .out_valid(out_valid), .acc(acc), .result_hi(result_hi), .err(err)
  );

  // behavioural datapath: ripple adder/subtractor, multiplier, result mux
  logic [15:0] dp_sum;
  int          dp_idx;
  always_comb begin
    dp_idx = -1;
    for (int i = 0; i < 32; i++) if (sel[i]) dp_idx = i;
    dp_sum       = mode ? (op_a - op_b) : (op_a + op_b);
    add_overflow = mode ? ((op_a[15] != op_b[15]) && (dp_sum[15] != op_a[15]))
                        : ((op_a[15] == op_b[15]) && (dp_sum[15] != op_a[15]));
    product      = {16'd0, op_a} * {16'd0, op_b};
    case (dp_idx)
      1, 2:    mux_result = dp_sum;
      3:       mux_result = product[15:0];
      4:       mux_result = op_a & op_b;
      5:       mux_result = op_a | op_b;
      6:       mux_result = op_a ^ op_b;
      7:       mux_result = ~op_a;
      8:       mux_result = {op_a[14:0], 1'b0};
      9:       mux_result = {1'b0, op_a[15:1]};
      10:      mux_result = op_a;
      default: mux_result = 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ua;
    logic        hold;   // keep in_valid high through SETTLE
    logic [15:0] e_acc;
    logic [15:0] e_hi;
    logic [1:0]  e_err;
    int          e_lat;  // posedges from accept to out_valid
    logic [31:0] e_sel;
    logic        e_mode;
  } vec_t;

  localparam int NV = 19;
  vec_t        vecs [NV];
  logic [15:0] model_acc = 16'h0;

  task automatic run_op(input int k);
    vec_t        v;
    int          lat;
    bit          seen;
    logic [15:0] exp_a;
    v     = vecs[k];
    exp_a = v.ua ? model_acc : v.a;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    chk($sformatf("v%0d ready_before", k), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1; opcode = v.op; data_a = v.a; data_b = v.b; use_acc = v.ua;
    @(posedge clk); #1;
    if (!v.hold) in_valid = 1'b0;
    data_a = 16'hBEEF;
    lat = 0; seen = 0;
    while (lat <= 20) begin
      if (out_valid) begin seen = 1; break; end
      chk($sformatf("v%0d sel c%0d", k, lat), sel, v.e_sel);
      chk($sformatf("v%0d mode c%0d", k, lat), {31'd0, mode}, {31'd0, v.e_mode});
      chk($sformatf("v%0d op_a c%0d", k, lat), {16'd0, op_a}, {16'd0, exp_a});
      chk($sformatf("v%0d op_b c%0d", k, lat), {16'd0, op_b}, {16'd0, v.b});
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid_seen", k), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d latency", k), lat, v.e_lat);
    chk($sformatf("v%0d acc", k), {16'd0, acc}, {16'd0, v.e_acc});
    chk($sformatf("v%0d result_hi", k), {16'd0, result_hi}, {16'd0, v.e_hi});
    chk($sformatf("v%0d err", k), {30'd0, err}, {30'd0, v.e_err});
    chk($sformatf("v%0d sel_done", k), sel, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d pulse_width", k), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d ready_after", k), {31'd0, in_ready}, 32'd1);
    chk($sformatf("v%0d err_hold", k), {30'd0, err}, {30'd0, v.e_err});
    model_acc = v.e_acc;
  endtask

  initial begin
    bit pulsed;
    //          op     a         b         ua  hold e_acc     e_hi      err   lat sel            mode
    vecs[0]  = '{4'd1,  16'h000F, 16'h0007, 0, 0, 16'h0016, 16'h0000, 2'd0, 1, 32'h0000_0002, 0};
    vecs[1]  = '{4'd2,  16'h8000, 16'h0001, 0, 0, 16'h7FFF, 16'h0000, 2'd1, 1, 32'h0000_0004, 1};
    vecs[2]  = '{4'd3,  16'h000F, 16'h0007, 0, 1, 16'h0069, 16'h0000, 2'd0, 4, 32'h0000_0008, 0};
    vecs[3]  = '{4'd3,  16'h0100, 16'h0100, 0, 0, 16'h0000, 16'h0001, 2'd1, 4, 32'h0000_0008, 0};
    vecs[4]  = '{4'd4,  16'hF0F0, 16'h0FF0, 0, 0, 16'h00F0, 16'h0000, 2'd0, 1, 32'h0000_0010, 0};
    vecs[5]  = '{4'd11, 16'hAAAA, 16'h5555, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 32'h0000_0000, 0};
    vecs[6]  = '{4'd10, 16'h0005, 16'h0000, 0, 0, 16'h0005, 16'h0000, 2'd0, 1, 32'h0000_0400, 0};
    vecs[7]  = '{4'd1,  16'h1234, 16'h0003, 1, 0, 16'h0008, 16'h0000, 2'd0, 1, 32'h0000_0002, 0};
    vecs[8]  = '{4'd13, 16'h0001, 16'h0002, 0, 0, 16'h0008, 16'h0000, 2'd2, 0, 32'h0000_0000, 0};
    vecs[9]  = '{4'd6,  16'hFFFF, 16'h00FF, 0, 0, 16'hFF00, 16'h0000, 2'd0, 1, 32'h0000_0040, 0};
    vecs[10] = '{4'd7,  16'h1234, 16'h0000, 0, 0, 16'hEDCB, 16'h0000, 2'd0, 1, 32'h0000_0080, 0};
    vecs[11] = '{4'd8,  16'h8001, 16'h0000, 0, 0, 16'h0002, 16'h0000, 2'd0, 1, 32'h0000_0100, 0};
    vecs[12] = '{4'd9,  16'h8001, 16'h0000, 0, 0, 16'h4000, 16'h0000, 2'd0, 1, 32'h0000_0200, 0};
    vecs[13] = '{4'd5,  16'h1200, 16'h0034, 0, 0, 16'h1234, 16'h0000, 2'd0, 1, 32'h0000_0020, 0};
    vecs[14] = '{4'd1,  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 2'd0, 1, 32'h0000_0002, 0};
    vecs[15] = '{4'd1,  16'h7FFF, 16'h0001, 0, 0, 16'h8000, 16'h0000, 2'd1, 1, 32'h0000_0002, 0};
    vecs[16] = '{4'd12, 16'h0000, 16'h0000, 0, 0, 16'h8000, 16'h0000, 2'd2, 0, 32'h0000_0000, 0};
    vecs[17] = '{4'd0,  16'h1111, 16'h2222, 0, 0, 16'h8000, 16'h0000, 2'd0, 0, 32'h0000_0000, 0};
    vecs[18] = '{4'd3,  16'h00FF, 16'h0101, 0, 0, 16'hFFFF, 16'h0000, 2'd0, 4, 32'h0000_0008, 0};

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; data_a = '0; data_b = '0; use_acc = 1'b0;
    #12;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst sel", sel, 32'd0);
    chk("rst acc", {16'd0, acc}, 32'd0);
    chk("rst result_hi", {16'd0, result_hi}, 32'd0);
    chk("rst err", {30'd0, err}, 32'd0);
    chk("rst op_a_b_mode", {op_a, op_b[14:0], mode}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < NV; k++) run_op(k);

    // reset during MUL settle: aborted op produces nothing, acc clears
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd3; data_a = 16'h0003; data_b = 16'h0005; use_acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort sel_mid", sel, 32'h0000_0008);
    rst_n = 1'b0; #1;
    chk("abort acc", {16'd0, acc}, 32'd0);
    chk("abort sel", sel, 32'd0);
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulsed = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulsed = 1;
    end
    chk("abort no_pulse", {31'd0, pulsed}, 32'd0);
    chk("abort ready_after", {31'd0, in_ready}, 32'd1);
    chk("abort acc_after", {16'd0, acc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front end for the 16-bit ALU datapath. It accepts one operation per valid/ready handshake, registers the operands, and drives a one-hot select onto the 32-channel 16-bit result mux. It holds the datapath inputs stable for a programmable settle time, so the ripple adder and the ripple-array multiplier can resolve. It then captures the mux result, the multiplier upper half, and the error flags into an accumulator.

## Interface
Parameters:
- SETTLE_ALU, default 1: cycles to hold operands for non-multiply ops (≥1).
- SETTLE_MUL, default 4: cycles to hold operands for MUL (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- opcode  in  4  operation code (map below)
- data_a  in  16  operand A
- data_b  in  16  operand B
- use_acc  in  1  1: operand A = current acc, data_a ignored
- sel  out  32  one-hot select to result mux; sel[opcode] for legal mux ops
- op_a  out  16  registered operand A to datapath
- op_b  out  16  registered operand B to datapath
- mode  out  1  AddSub mode: 1 for SUB, else 0
- mux_result  in  16  result mux output
- add_overflow  in  1  AddSub overflow
- product  in  32  multiplier output
- out_valid  out  1  one-cycle pulse: result captured
- acc  out  16  accumulator
- result_hi  out  16  product[31:16] of last MUL; 0 after any other op
- err  out  2  00 ok, 01 arithmetic overflow, 10 illegal opcode

## Operation
Opcode map:
- 0 NOP
- 1 ADD
- 2 SUB
- 3 MUL
- 4 AND
- 5 OR
- 6 XOR
- 7 NOT A
- 8 SHL1
- 9 SHR1
- 10 PASS A
- 11 CLR
- 12–15 illegal

Mux ops are 1–10. For these, sel = 1<<opcode while in SETTLE; otherwise sel = 0.

FSM states: IDLE, SETTLE, DONE.
- IDLE: in_ready=1. On in_valid:
  - Register opcode, op_a (acc if use_acc), op_b and mode.
  - Load cnt = SETTLE_MUL-1 for MUL, or SETTLE_ALU-1 for other mux ops.
  - Go to SETTLE.
  - NOP, CLR and illegal opcodes skip SETTLE and go straight to DONE.
- SETTLE: in_ready=0; sel, op_a, op_b and mode are held constant.
  - cnt≠0: decrement cnt.
  - cnt=0: capture results per the rules below and go to DONE.
- DONE: out_valid=1 for exactly one cycle, then go to IDLE. in_ready=0 in DONE.

Capture rules (applied on the SETTLE→DONE edge, or the IDLE→DONE edge for non-mux ops):
- Mux ops: acc←mux_result.
- MUL: result_hi←product[31:16]; err=01 if product[31:16]≠0.
- All non-MUL ops: result_hi←0.
- ADD/SUB: err=01 if add_overflow.
- Other legal mux ops: err=00.
- NOP: acc unchanged, err=00.
- CLR: acc←0, err=00.
- Illegal opcode: acc unchanged, err=10.

Output holding:
- err and result_hi hold their value until the next capture.
- op_a, op_b and mode hold their last value in IDLE/DONE.
- sel is 0 outside SETTLE.

Arithmetic:
- All results are 16-bit and wrap modulo 2^16.
- The overflow flag is reported only; it never saturates the result.

## Timing
- Reset values (all asynchronous): state IDLE, in_ready=1, out_valid=0, sel=0, op_a=0, op_b=0, mode=0, acc=0, result_hi=0, err=00, cnt=0.
- Accept edge E0 (in_valid & in_ready): sel is valid from the cycle after E0.
- Latency for a mux op with settle N:
  - Capture occurs on edge E0+N.
  - out_valid is high in cycle E0+N to E0+N+1.
  - in_ready returns on edge E0+N+1.
- Latency for NOP, CLR and illegal opcodes: capture on E0; out_valid is high in the following cycle.
- Throughput: one op per N+2 cycles (mux ops) or 2 cycles (non-mux ops).
- in_valid while in_ready=0 is ignored; the requester must hold the request until it sees in_ready.
- use_acc samples acc at E0, so back-to-back chained ops see the previous result.
- Reset asserted mid-operation:
  - Immediately return to IDLE, sel=0, acc=0.
  - No out_valid pulse is produced for the aborted op.

## Test plan
- ADD 15+7, SETTLE_ALU=1 → out_valid exactly 1 cycle after accept, acc=22, err=00, sel=0x0000_0002 during SETTLE.
- SUB 0x8000−0x0001 → acc=0x7FFF, err=01, mode=1 throughout SETTLE.
- MUL 15×7, SETTLE_MUL=4 → out_valid exactly 4 cycles after accept, acc=105, result_hi=0, err=00; in_valid held high during SETTLE is not accepted early.
- MUL 0x0100×0x0100 → acc=0x0000, result_hi=0x0001, err=01; a following AND clears result_hi to 0.
- Chain: CLR; then PASS A 5; then ADD use_acc with B=3 → acc 0, then 5, then 8, with three out_valid pulses.
- Opcode 13 → out_valid 1 cycle after accept, err=10, acc unchanged, sel stays 0.
- Reset asserted during MUL SETTLE → acc=0, sel=0, no out_valid pulse; in_ready=1 after release.
